// File: rtl/bsg_axi_lite_bridge_pkg.sv
// Shared types and elaboration helpers for the AXI-Lite to multi-channel FIFO bridge.
package bsg_axi_lite_bridge_pkg;

  typedef enum logic [1:0] {
    resp_okay   = 2'b00,
    resp_slverr = 2'b10,
    resp_decerr = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    off_data     = 2'd0,
    off_rx_count = 2'd1,
    off_tx_free  = 2'd2,
    off_rsvd     = 2'd3
  } off_e;

  typedef enum logic [1:0] {
    w_idle = 2'd0,
    w_hold = 2'd1,
    w_resp = 2'd2
  } w_state_e;

  typedef enum logic {
    r_idle = 1'b0,
    r_resp = 1'b1
  } r_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the values 0..n inclusive.
  function automatic int width_of(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_axi_lite_fifo_bridge_multi_if.sv
// AXI-Lite slave port bundle for the FIFO bridge.
interface bsg_axi_lite_fifo_bridge_multi_if #(
  parameter int addr_width_p = 32
);
  // Every channel transfers on a cycle where valid and ready are both high;
  // valid never waits on ready and payload holds stable while valid is up.
  logic [addr_width_p-1:0] awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [addr_width_p-1:0] araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/bsg_axi_lite_bridge_channel.sv
// One bridge channel: a TX FIFO (host -> fabric) and an RX FIFO (fabric -> host),
// each with its own occupancy counter.
module bsg_axi_lite_bridge_channel
  import bsg_axi_lite_bridge_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int tx_els_p     = 4,
  parameter int rx_els_p     = 32,
  parameter int cnt_w_p      = 6
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    tx_enq,
  input  logic [data_width_p-1:0] tx_wdata,
  output logic                    tx_full,
  output logic [cnt_w_p-1:0]      tx_count,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  input  logic                    yumi_i,
  input  logic                    v_i,
  input  logic [data_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    rx_valid,
  output logic [data_width_p-1:0] rx_data,
  input  logic                    rx_deq,
  output logic [cnt_w_p-1:0]      rx_count
);

  localparam int tx_ptr_w_lp = safe_clog2(tx_els_p);
  localparam int rx_ptr_w_lp = safe_clog2(rx_els_p);

  logic [data_width_p-1:0] tx_mem [tx_els_p];
  logic [data_width_p-1:0] rx_mem [rx_els_p];
  logic [tx_ptr_w_lp-1:0]  tx_wptr_q, tx_rptr_q;
  logic [rx_ptr_w_lp-1:0]  rx_wptr_q, rx_rptr_q;
  logic [cnt_w_p-1:0]      tx_cnt_q, rx_cnt_q;
  logic                    rx_enq;

  assign tx_full  = (tx_cnt_q == cnt_w_p'(tx_els_p));
  assign tx_count = tx_cnt_q;
  assign v_o      = (tx_cnt_q != '0);
  assign data_o   = tx_mem[tx_rptr_q];

  // ready_o is forced low while reset is held, even though the counter is already zero.
  assign ready_o  = reset_n_i & (rx_cnt_q != cnt_w_p'(rx_els_p));
  assign rx_enq   = v_i & ready_o;
  assign rx_valid = (rx_cnt_q != '0);
  assign rx_data  = rx_mem[rx_rptr_q];
  assign rx_count = rx_cnt_q;

  always_ff @(posedge clk_i) begin
    if (tx_enq) tx_mem[tx_wptr_q] <= tx_wdata;
    if (rx_enq) rx_mem[rx_wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (tx_enq)
        tx_wptr_q <= (tx_wptr_q == tx_ptr_w_lp'(tx_els_p - 1)) ? '0 : tx_wptr_q + 1'b1;
      if (yumi_i)
        tx_rptr_q <= (tx_rptr_q == tx_ptr_w_lp'(tx_els_p - 1)) ? '0 : tx_rptr_q + 1'b1;
      if (rx_enq)
        rx_wptr_q <= (rx_wptr_q == rx_ptr_w_lp'(rx_els_p - 1)) ? '0 : rx_wptr_q + 1'b1;
      if (rx_deq)
        rx_rptr_q <= (rx_rptr_q == rx_ptr_w_lp'(rx_els_p - 1)) ? '0 : rx_rptr_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + cnt_w_p'(tx_enq) - cnt_w_p'(yumi_i);
      rx_cnt_q <= rx_cnt_q + cnt_w_p'(rx_enq) - cnt_w_p'(rx_deq);
    end
  end

  tx_pop_needs_data: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o));

endmodule

// File: rtl/bsg_axi_lite_fifo_bridge_multi.sv
// AXI-Lite slave mapping host register accesses onto num_channels_p TX/RX FIFO pairs.
// Address map per channel (16 bytes): DATA, RX_COUNT, TX_FREE, reserved.
module bsg_axi_lite_fifo_bridge_multi
  import bsg_axi_lite_bridge_pkg::*;
#(
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  parameter int num_channels_p = 4,
  parameter int tx_els_p       = 4,
  parameter int rx_els_p       = 32
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  bsg_axi_lite_fifo_bridge_multi_if.slave               axi,
  output logic [num_channels_p-1:0]                     v_o,
  output logic [num_channels_p-1:0][data_width_p-1:0]   data_o,
  input  logic [num_channels_p-1:0]                     yumi_i,
  input  logic [num_channels_p-1:0]                     v_i,
  input  logic [num_channels_p-1:0][data_width_p-1:0]   data_i,
  output logic [num_channels_p-1:0]                     ready_o,
  output w_state_e                                      wr_state,
  output r_state_e                                      rd_state
);

  localparam int lg_ch_lp = safe_clog2(num_channels_p);
  localparam int cnt_w_lp = width_of(max_of(tx_els_p, rx_els_p));

  logic [num_channels_p-1:0] tx_enq, tx_full, rx_valid, rx_deq;
  logic [data_width_p-1:0]   rx_head [num_channels_p];
  logic [cnt_w_lp-1:0]       tx_cnt  [num_channels_p];
  logic [cnt_w_lp-1:0]       rx_cnt  [num_channels_p];

  logic                    aw_full_q, w_full_q, aw_fire, w_fire, w_clear;
  logic [addr_width_p-1:0] aw_addr_q;
  logic [data_width_p-1:0] w_data_q;
  logic [3:0]              w_strb_q;
  w_state_e                w_state_q, w_state_n;
  resp_e                   bresp_q, bresp_n;

  r_state_e                r_state_q, r_state_n;
  resp_e                   rresp_q, rresp_n;
  logic [data_width_p-1:0] rdata_q, rdata_n;

  logic unused;
  assign unused = ^{axi.awprot, axi.arprot};

  // Misaligned, above the channel window, or naming a channel that does not exist.
  function automatic logic addr_decerr(input logic [addr_width_p-1:0] a);
    logic [addr_width_p-1:0] upper;
    upper = a >> (4 + lg_ch_lp);
    return (a[1:0] != 2'b00) || (upper != '0) || (int'(a[4 +: lg_ch_lp]) >= num_channels_p);
  endfunction

  for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
    bsg_axi_lite_bridge_channel #(
      .data_width_p(data_width_p),
      .tx_els_p    (tx_els_p),
      .rx_els_p    (rx_els_p),
      .cnt_w_p     (cnt_w_lp)
    ) chan (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .tx_enq   (tx_enq[c]),
      .tx_wdata (w_data_q),
      .tx_full  (tx_full[c]),
      .tx_count (tx_cnt[c]),
      .v_o      (v_o[c]),
      .data_o   (data_o[c]),
      .yumi_i   (yumi_i[c]),
      .v_i      (v_i[c]),
      .data_i   (data_i[c]),
      .ready_o  (ready_o[c]),
      .rx_valid (rx_valid[c]),
      .rx_data  (rx_head[c]),
      .rx_deq   (rx_deq[c]),
      .rx_count (rx_cnt[c])
    );
  end

  // ---------------- write path ----------------
  logic [lg_ch_lp-1:0] w_ch;
  off_e                w_off;
  logic                w_dec;

  assign w_ch  = aw_addr_q[4 +: lg_ch_lp];
  assign w_off = off_e'(aw_addr_q[3:2]);
  assign w_dec = addr_decerr(aw_addr_q);

  always_comb begin
    w_state_n   = w_state_q;
    bresp_n     = bresp_q;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    w_clear     = 1'b0;
    tx_enq      = '0;
    case (w_state_q)
      w_idle: begin
        axi.awready = reset_n_i & ~aw_full_q;
        axi.wready  = reset_n_i & ~w_full_q;
        aw_fire     = axi.awvalid & axi.awready;
        w_fire      = axi.wvalid & axi.wready;
        if ((aw_full_q | aw_fire) && (w_full_q | w_fire)) w_state_n = w_hold;
      end
      w_hold: begin
        if (w_dec) begin
          bresp_n   = resp_decerr;
          w_state_n = w_resp;
        end else if (w_off != off_data || w_strb_q != 4'hF) begin
          bresp_n   = resp_slverr;
          w_state_n = w_resp;
        end else if (!tx_full[w_ch]) begin
          tx_enq[w_ch] = 1'b1;
          bresp_n      = resp_okay;
          w_state_n    = w_resp;
        end
      end
      w_resp: begin
        if (axi.bready) begin
          w_clear   = 1'b1;
          w_state_n = w_idle;
        end
      end
      default: w_state_n = w_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_state_q <= w_idle;
      bresp_q   <= resp_okay;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      w_state_q <= w_state_n;
      bresp_q   <= bresp_n;
      if (aw_fire) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= axi.awaddr;
      end else if (w_clear) begin
        aw_full_q <= 1'b0;
      end
      if (w_fire) begin
        w_full_q <= 1'b1;
        w_data_q <= axi.wdata;
        w_strb_q <= axi.wstrb;
      end else if (w_clear) begin
        w_full_q <= 1'b0;
      end
    end
  end

  assign axi.bvalid = (w_state_q == w_resp);
  assign axi.bresp  = bresp_q;
  assign wr_state   = w_state_q;

  // ---------------- read path ----------------
  logic [lg_ch_lp-1:0] r_ch;
  off_e                r_off;

  assign r_ch  = axi.araddr[4 +: lg_ch_lp];
  assign r_off = off_e'(axi.araddr[3:2]);

  // The response is formed in the acceptance cycle, so counts reflect registered occupancy.
  always_comb begin
    r_state_n   = r_state_q;
    rdata_n     = rdata_q;
    rresp_n     = rresp_q;
    axi.arready = 1'b0;
    rx_deq      = '0;
    case (r_state_q)
      r_idle: begin
        axi.arready = reset_n_i;
        if (axi.arvalid && reset_n_i) begin
          r_state_n = r_resp;
          rdata_n   = '0;
          rresp_n   = resp_okay;
          if (addr_decerr(axi.araddr)) begin
            rresp_n = resp_decerr;
          end else begin
            case (r_off)
              off_data: begin
                if (rx_valid[r_ch]) begin
                  rx_deq[r_ch] = 1'b1;
                  rdata_n      = rx_head[r_ch];
                end else begin
                  rresp_n = resp_slverr;
                end
              end
              off_rx_count: rdata_n = data_width_p'(rx_cnt[r_ch]);
              off_tx_free:  rdata_n = data_width_p'(tx_els_p) - data_width_p'(tx_cnt[r_ch]);
              default:      rdata_n = '0;
            endcase
          end
        end
      end
      r_resp: begin
        if (axi.rready) r_state_n = r_idle;
      end
      default: r_state_n = r_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state_q <= r_idle;
      rdata_q   <= '0;
      rresp_q   <= resp_okay;
    end else begin
      r_state_q <= r_state_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
    end
  end

  assign axi.rvalid = (r_state_q == r_resp);
  assign axi.rdata  = rdata_q;
  assign axi.rresp  = rresp_q;
  assign rd_state   = r_state_q;

endmodule
